// File: rtl/riscv32ima_mem_arb_if.sv
// riscv32ima native memory bus: active-low chip select / write enable with
// a stall back-channel. One instance per requester port and one for memory.
interface riscv32ima_mem_arb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    logic                  ncs;
    logic                  nwe;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] wmask;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  stall;

    // Side that issues requests.
    modport master (output ncs, nwe, addr, wdata, wmask, input rdata, stall);
    // Side that services requests.
    modport slave  (input ncs, nwe, addr, wdata, wmask, output rdata, stall);
endinterface

// File: rtl/riscv32ima_mem_arb.sv
// Two-to-one arbiter sharing one single-ported, one-cycle-latency memory
// between the instruction-fetch port (i_bus) and load/store port (d_bus).
// Grant is combinational from registered state and is locked while memory
// stalls; read data is steered back to, and held for, the issuing port.
// Optional: define RISCV32IMA_MEM_ARB_RR_EN for round-robin on contested
// cycles instead of d-priority with a fetch starvation bound.
module riscv32ima_mem_arb #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    riscv32ima_mem_arb_if.slave   i_bus,
    riscv32ima_mem_arb_if.slave   d_bus,
    riscv32ima_mem_arb_if.master  m_bus
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOCK_I, ST_LOCK_D} state_e;
    typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} port_e;

    state_e                state_q, state_d;
    logic                  rsel_vld_q, rsel_vld_d;
    port_e                 rsel_port_q, rsel_port_d;
    logic [DATA_WIDTH-1:0] i_hold_q, i_hold_d;
    logic [DATA_WIDTH-1:0] d_hold_q, d_hold_d;
`ifdef RISCV32IMA_MEM_ARB_RR_EN
    port_e                 last_gnt_q, last_gnt_d;
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    logic [3:0]            starve_cnt_q, starve_cnt_d;
`endif

    logic  i_req, d_req;
    logic  gnt_vld;
    port_e gnt_port;
    port_e contest_win;
    logic  accept;
    logic  sel_nwe;
    logic  i_ret, d_ret;

    assign i_req = ~i_bus.ncs;
    assign d_req = ~d_bus.ncs;

`ifdef RISCV32IMA_MEM_ARB_RR_EN
    assign contest_win = (last_gnt_q == PORT_I) ? PORT_D : PORT_I;
`else
    assign contest_win = (starve_cnt_q == STARVE_LIM) ? PORT_I : PORT_D;
`endif

    // Grant selection: free arbitration in IDLE, forced to the owner when locked.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        gnt_vld  = 1'b0;
        gnt_port = PORT_D;
        unique case (state_q)
            ST_IDLE: begin
                if (i_req && d_req) begin
                    gnt_vld  = 1'b1;
                    gnt_port = contest_win;
                end else if (i_req) begin
                    gnt_vld  = 1'b1;
                    gnt_port = PORT_I;
                end else if (d_req) begin
                    gnt_vld  = 1'b1;
                    gnt_port = PORT_D;
                end
            end
            // A dropped request while locked is a protocol violation: no grant.
            ST_LOCK_I: begin
                gnt_vld  = i_req;
                gnt_port = PORT_I;
            end
            ST_LOCK_D: begin
                gnt_vld  = d_req;
                gnt_port = PORT_D;
            end
            default: ;
        endcase
        if (rst) gnt_vld = 1'b0;
    end

    assign sel_nwe = (gnt_port == PORT_I) ? i_bus.nwe : d_bus.nwe;
    assign accept  = gnt_vld & ~m_bus.stall;

    // Memory request mux; idle bus drives zeros with ncs/nwe deasserted.
    assign m_bus.ncs   = ~gnt_vld;
    assign m_bus.nwe   = gnt_vld ? sel_nwe : 1'b1;
    assign m_bus.addr  = !gnt_vld ? '0 : (gnt_port == PORT_I) ? i_bus.addr  : d_bus.addr;
    assign m_bus.wdata = !gnt_vld ? '0 : (gnt_port == PORT_I) ? i_bus.wdata : d_bus.wdata;
    assign m_bus.wmask = !gnt_vld ? '0 : (gnt_port == PORT_I) ? i_bus.wmask : d_bus.wmask;

    assign i_bus.stall = rst | (i_req & (~(gnt_vld & (gnt_port == PORT_I)) | m_bus.stall));
    assign d_bus.stall = rst | (d_req & (~(gnt_vld & (gnt_port == PORT_D)) | m_bus.stall));

    // Read return: live memory data in the return cycle, hold register after.
    assign i_ret = rsel_vld_q & (rsel_port_q == PORT_I);
    assign d_ret = rsel_vld_q & (rsel_port_q == PORT_D);
    assign i_bus.rdata = rst ? '0 : i_ret ? m_bus.rdata : i_hold_q;
    assign d_bus.rdata = rst ? '0 : d_ret ? m_bus.rdata : d_hold_q;

    // Next-state computation for FSM, return routing, holds and fairness state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (gnt_vld && m_bus.stall)
                           state_d = (gnt_port == PORT_I) ? ST_LOCK_I : ST_LOCK_D;
            ST_LOCK_I,
            ST_LOCK_D: if (!gnt_vld || !m_bus.stall) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        rsel_vld_d  = accept & sel_nwe;
        rsel_port_d = gnt_port;
        i_hold_d    = i_ret ? m_bus.rdata : i_hold_q;
        d_hold_d    = d_ret ? m_bus.rdata : d_hold_q;

`ifdef RISCV32IMA_MEM_ARB_RR_EN
        last_gnt_d = accept ? gnt_port : last_gnt_q;
`else
        starve_cnt_d = starve_cnt_q;
        if (accept && gnt_port == PORT_I)
            starve_cnt_d = '0;
        else if (accept && i_req && starve_cnt_q != STARVE_LIM)
            starve_cnt_d = starve_cnt_q + 4'd1;
`endif
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= ST_IDLE;
            rsel_vld_q  <= 1'b0;
            rsel_port_q <= PORT_I;
            // NOTE: the hold registers are plain flops, not a memory array, so
            // they are reset to give defined rdata right after reset.
            i_hold_q    <= '0;
            d_hold_q    <= '0;
`ifdef RISCV32IMA_MEM_ARB_RR_EN
            last_gnt_q  <= PORT_I;
`else
            starve_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rsel_vld_q  <= rsel_vld_d;
            rsel_port_q <= rsel_port_d;
            i_hold_q    <= i_hold_d;
            d_hold_q    <= d_hold_d;
`ifdef RISCV32IMA_MEM_ARB_RR_EN
            last_gnt_q  <= last_gnt_d;
`else
            starve_cnt_q <= starve_cnt_d;
`endif
        end
    end

endmodule
